// File: rtl/ring_pkg.sv
// Shared definitions for the clockwise ring stages: flit geometry and the
// one-hot input-slot state encoding used by input, CW-output and PE-output blocks.
package ring_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int VC_BIT     = 63;
  localparam int HOP_MSB    = 55;
  localparam int HOP_LSB    = 48;

  typedef logic [DATA_WIDTH-1:0] flit_t;

  typedef enum logic [2:0] {
    EMPTY  = 3'b001,
    REQ_CW = 3'b010,
    REQ_PE = 3'b100
  } slot_state_t;

  // A spent hop count means the flit has reached its destination PE.
  function automatic slot_state_t route_of(input flit_t f);
    return (f[HOP_MSB:HOP_LSB] == '0) ? REQ_PE : REQ_CW;
  endfunction

endpackage

// File: rtl/cw_input_if.sv
// Clockwise link and slot-to-output handshake bundle of the ring input stage.
interface cw_input_if;
  import ring_pkg::*;

  logic  cwsi;
  flit_t cwdi;
  logic  cwri;
  flit_t data_out_even;
  flit_t data_out_odd;
  logic  request_cw_even;
  logic  request_cw_odd;
  logic  request_pe_even;
  logic  request_pe_odd;
  logic  grant_cw_even;
  logic  grant_cw_odd;
  logic  grant_pe_even;
  logic  grant_pe_odd;

  // Environment side: upstream router plus the CW/PE output stages.
  modport master (
    output cwsi, cwdi, grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd,
    input  cwri, data_out_even, data_out_odd,
           request_cw_even, request_cw_odd, request_pe_even, request_pe_odd
  );

  modport slave (
    input  cwsi, cwdi, grant_cw_even, grant_cw_odd, grant_pe_even, grant_pe_odd,
    output cwri, data_out_even, data_out_odd,
           request_cw_even, request_cw_odd, request_pe_even, request_pe_odd
  );

endinterface

// File: rtl/input_vc_slot.sv
// Single-entry virtual-channel buffer: captures a flit, requests the output its
// hop field selects, and frees (or reloads) on the matching grant.
module input_vc_slot
  import ring_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  flit_t wr_data,
  input  logic  grant_cw,
  input  logic  grant_pe,
  output flit_t data,
  output logic  request_cw,
  output logic  request_pe,
  output logic  empty,
  output logic  drop
);

  slot_state_t state, state_next;
  logic        releasing;
  logic        accept;

  // Only the grant for the output actually being requested frees the slot.
  assign releasing = ((state == REQ_CW) && grant_cw) ||
                     ((state == REQ_PE) && grant_pe);
  assign accept    = wr_en && ((state == EMPTY) || releasing);
  assign drop      = wr_en && !accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  // NOTE: the default at the top of the block keeps this purely combinational;
  // without it, paths that skip an assignment would infer a latch.
  always_comb begin
    state_next = state;
    if (accept)         state_next = route_of(wr_data);
    else if (releasing) state_next = EMPTY;
  end

  always_comb begin
    request_cw = (state == REQ_CW);
    request_pe = (state == REQ_PE);
    empty      = (state == EMPTY);
  end

  // NOTE: the payload register is reset because data_out must read zero out of
  // reset; otherwise a datapath register like this would need no reset.
  always_ff @(posedge clk) begin
    if (!rst)        data <= '0;
    else if (accept) data <= wr_data;
  end

endmodule

// File: rtl/cw_input.sv
// Clockwise ring input stage: steers incoming flits to the even/odd slot by VC
// bit, gates upstream ready by router phase, and flags dropped writes.
module cw_input
  import ring_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       polarity,
  cw_input_if.slave  ring,
  output logic       overflow
);

  logic wr_even, wr_odd;
  logic empty_even, empty_odd;
  logic drop_even, drop_odd;

  // Slot choice follows the flit's own VC bit, not the current phase.
  assign wr_even = ring.cwsi && !ring.cwdi[VC_BIT];
  assign wr_odd  = ring.cwsi &&  ring.cwdi[VC_BIT];

  input_vc_slot u_even (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_even),
    .wr_data    (ring.cwdi),
    .grant_cw   (ring.grant_cw_even),
    .grant_pe   (ring.grant_pe_even),
    .data       (ring.data_out_even),
    .request_cw (ring.request_cw_even),
    .request_pe (ring.request_pe_even),
    .empty      (empty_even),
    .drop       (drop_even)
  );

  input_vc_slot u_odd (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_odd),
    .wr_data    (ring.cwdi),
    .grant_cw   (ring.grant_cw_odd),
    .grant_pe   (ring.grant_pe_odd),
    .data       (ring.data_out_odd),
    .request_cw (ring.request_cw_odd),
    .request_pe (ring.request_pe_odd),
    .empty      (empty_odd),
    .drop       (drop_odd)
  );

  assign ring.cwri = polarity ? empty_odd : empty_even;

  always_ff @(posedge clk) begin
    if (!rst)                       overflow <= 1'b0;
    else if (drop_even || drop_odd) overflow <= 1'b1;
  end

endmodule
